mux4way16_arbiter: RTL and testbench

MUX4WAY16_ARBITER -- requirements
Module: mux4way16_arbiter

---
 rtl/mux4way16_arbiter_if.sv | 30 +++
 rtl/mux4way16_arbiter.sv | 84 ++++++++
 tb/tb_mux4way16_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mux4way16_arbiter_if.sv
// Purpose: bundles the four source channels and the single sink of the 4:1 merge arbiter.
// Latency: none; this is wiring only.
// Backpressure: in_ready flows from the arbiter back to the sources; out_ready flows from the consumer back to the arbiter.
// Ports: in_valid/in_ready are per-channel handshakes (bit i belongs to in_data_i);
//        out_valid/out_ready/out_data/out_sel form the merged sink.
//        The slave modport is the arbiter; the master modport is its environment (sources plus consumer).
interface mux4way16_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data_0;
  logic [WIDTH-1:0] in_data_1;
  logic [WIDTH-1:0] in_data_2;
  logic [WIDTH-1:0] in_data_3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport master (
    output in_valid, in_data_0, in_data_1, in_data_2, in_data_3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data_0, in_data_1, in_data_2, in_data_3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux4way16_arbiter.sv
// Purpose: merges four valid/ready channels into one registered sink using round-robin arbitration.
// Latency: one cycle from input acceptance to out_valid; sustains one word per cycle.
// Backpressure: while out_valid && !out_ready the held word is frozen and in_ready is all zero.
// Ports: clk, reset_n (synchronous, active-low); bus.slave carries in_valid[3:0], in_data_0..3, in_ready[3:0],
//        out_valid, out_data, out_sel[1:0] and out_ready.
module mux4way16_arbiter #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               reset_n,
  mux4way16_arbiter_if.slave bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;
  logic [1:0]       last_q;

  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_dat;

  // The register can take a new word when it is empty or is being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // The search starts just after the last winner and wraps; the 2-bit add supplies the mod-4 wrap.
  always_comb begin
    logic [1:0] idx;
    grant     = 2'd0;
    grant_vld = 1'b0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!grant_vld && bus.in_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // in_ready depends only on in_valid, load_en and last, so data can never create a combinational path into it.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (reset_n && grant_vld && load_en) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    grant_dat = '0;
    case (grant)
      2'd0: grant_dat = bus.in_data_0;
      2'd1: grant_dat = bus.in_data_1;
      2'd2: grant_dat = bus.in_data_2;
      default: grant_dat = bus.in_data_3;
    endcase
  end

  // After reset last points at channel 3, so channel 0 has highest priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      last_q      <= 2'd3;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_dat;
        out_sel_q   <= grant;
        last_q      <= grant;
      end else begin
        // When no source is offering data, the register empties; data, sel and last keep their old values.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4way16_arbiter.sv
module tb_mux4way16_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux4way16_arbiter_if #(.WIDTH(16)) bus ();

  mux4way16_arbiter #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_a0();
    bus.in_data_0 = 16'h00A0;
    bus.in_data_1 = 16'h00A1;
    bus.in_data_2 = 16'h00A2;
    bus.in_data_3 = 16'h00A3;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    set_data_a0();
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready_comb got=%b exp=0000", bus.in_ready); end
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", bus.out_data); end
    checks++;
    if (bus.out_sel !== 2'd0) begin failures++; $display("FAIL rst_out_sel got=%0d exp=0", bus.out_sel); end
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", bus.in_ready); end
  endtask

  task automatic test_single_then_drain();
    reset_n = 1'b1;
    bus.in_valid = 4'b0001;
    bus.in_data_0 = 16'h1234;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL single_in_ready got=%b exp=0001", bus.in_ready); end
    tick();
    bus.in_valid = 4'b0000;
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h1234) begin failures++; $display("FAIL single_out_data got=%h exp=1234", bus.out_data); end
    checks++;
    if (bus.out_sel !== 2'd0) begin failures++; $display("FAIL single_out_sel got=%0d exp=0", bus.out_sel); end
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL idle_in_ready got=%b exp=0000", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h1234) begin failures++; $display("FAIL drain_out_data_hold got=%h exp=1234", bus.out_data); end
  endtask

  task automatic test_round_robin();
    bus.in_valid = 4'b0000;
    bus.out_ready = 1'b1;
    set_data_a0();
    do_reset();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] exp_rdy;
      logic [1:0] exp_sel;
      exp_sel = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_sel;
      #1;
      checks++;
      if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, exp_rdy); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rr_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++;
      if (bus.out_sel !== exp_sel) begin failures++; $display("FAIL rr_out_sel[%0d] got=%0d exp=%0d", i, bus.out_sel, exp_sel); end
      checks++;
      if (bus.out_data !== 16'h00A0 + 16'(exp_sel)) begin
        failures++; $display("FAIL rr_out_data[%0d] got=%h exp=%h", i, bus.out_data, 16'h00A0 + 16'(exp_sel));
      end
    end
  endtask

  // Starts with last = 3, so channel 0 loads BEEF; then stall with all channels valid.
  task automatic test_backpressure();
    bus.in_valid = 4'b0001;
    bus.in_data_0 = 16'hBEEF;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_data !== 16'hBEEF) begin failures++; $display("FAIL bp_load got=%h exp=beef", bus.out_data); end
    set_data_a0();
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF || bus.out_sel !== 2'd0) begin
        failures++; $display("FAIL bp_hold[%0d] got=v%b d%h s%0d exp=v1 dbeef s0", i, bus.out_valid, bus.out_data, bus.out_sel);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=0010", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00A1 || bus.out_sel !== 2'd1) begin
      failures++; $display("FAIL bp_release_load got=v%b d%h s%0d exp=v1 d00a1 s1", bus.out_valid, bus.out_data, bus.out_sel);
    end
  endtask

  // last = 1 here, so with channels 0 and 3 requesting, 3 wins first and 0 follows with no bubble.
  task automatic test_skip_wrap();
    bus.in_valid = 4'b1001;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL skip_in_ready_a got=%b exp=1000", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.out_data !== 16'h00A3) begin
      failures++; $display("FAIL skip_first got=v%b s%0d d%h exp=v1 s3 d00a3", bus.out_valid, bus.out_sel, bus.out_data);
    end
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL skip_in_ready_b got=%b exp=0001", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h00A0) begin
      failures++; $display("FAIL skip_second got=v%b s%0d d%h exp=v1 s0 d00a0", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  // Entered with a word held (out_valid = 1) and last = 0.
  task automatic test_mid_reset();
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL mrst_in_ready_comb got=%b exp=0000", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_sel !== 2'd0) begin
      failures++; $display("FAIL mrst_regs got=v%b d%h s%0d exp=v0 d0000 s0", bus.out_valid, bus.out_data, bus.out_sel);
    end
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL mrst_in_ready got=%b exp=0000", bus.in_ready); end
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL mrst_release_in_ready got=%b exp=0001", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h00A0) begin
      failures++; $display("FAIL mrst_first_grant got=v%b s%0d d%h exp=v1 s0 d00a0", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  initial begin
    bus.in_valid = 4'b0000;
    bus.out_ready = 1'b0;
    set_data_a0();
    test_reset();
    test_single_then_drain();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
